moore_seq_controller: RTL and testbench

- Test sequencer for the 1101 Moore sequence detector (detection flag driven in state E).
- On a start request, it does three things:
  - Latches a pattern of up to 16 bits.
  - Clears the detector.
  - Shifts the pattern into the detector one bit per clock, LSB first.
- It counts the cycles in which the detector output is high and records where the first detection occurred.
- It sits between the user-pin input register and the detector instance, and owns the detector's input bit and reset.

---
 rtl/moore_seq_controller_if.sv | 26 ++
 rtl/moore_seq_controller.sv | 110 +++++++++++
 tb/tb_moore_seq_controller.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/moore_seq_controller_if.sv
// rtl/moore_seq_controller_if.sv - run request, results and detector-side signals of the 1101 test sequencer
interface moore_seq_controller_if #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8
);
    logic               start;
    logic [MAX_LEN-1:0] pat_data;
    logic [4:0]         pat_len;
    logic               det_x;
    logic               det_rst_n;
    logic               det_z;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   match_count;
    logic [4:0]         first_idx;

    modport master (
        output start, pat_data, pat_len, det_z,
        input  det_x, det_rst_n, busy, done, match_count, first_idx
    );

    modport slave (
        input  start, pat_data, pat_len, det_z,
        output det_x, det_rst_n, busy, done, match_count, first_idx
    );
endinterface

// File: rtl/moore_seq_controller.sv
// rtl/moore_seq_controller.sv - clears the 1101 detector, shifts a pattern in LSB first, counts matches
module moore_seq_controller #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    moore_seq_controller_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

    localparam logic [4:0] MAX_L    = 5'(MAX_LEN);
    localparam logic [4:0] NO_MATCH = 5'h1F;

    state_t             state;
    logic [MAX_LEN-1:0] shreg;
    logic [4:0]         len;
    logic [4:0]         idx;
    logic               det_rst_q;
    logic               sample_en;
    logic [4:0]         sample_idx;

    // Gating with rst keeps the detector cleared while reset is held, not just after the first edge.
    assign bus.det_rst_n = det_rst_q & ~rst;

    // det_z lags the presented bit by one cycle, so each sample belongs to the previous bit index.
    always_comb begin
        sample_en  = 1'b0;
        sample_idx = idx - 5'd1;
        if (state == SHIFT && idx != 5'd0) begin
            sample_en = 1'b1;
        end else if (state == DRAIN) begin
            sample_en  = 1'b1;
            sample_idx = len - 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            shreg           <= '0;
            len             <= 5'd0;
            idx             <= 5'd0;
            det_rst_q       <= 1'b1;
            bus.det_x       <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.match_count <= '0;
            bus.first_idx   <= NO_MATCH;
        end else begin
            if (sample_en && bus.det_z) begin
                if (bus.match_count != '1) begin
                    bus.match_count <= bus.match_count + 1'b1;
                end
                if (bus.first_idx == NO_MATCH) begin
                    bus.first_idx <= sample_idx;
                end
            end

            case (state)
                IDLE: begin
                    bus.det_x <= 1'b0;
                    det_rst_q <= 1'b1;
                    bus.busy  <= 1'b0;
                    bus.done  <= 1'b0;
                    if (bus.start) begin
                        shreg           <= bus.pat_data;
                        len             <= (bus.pat_len > MAX_L) ? MAX_L : bus.pat_len;
                        idx             <= 5'd0;
                        bus.match_count <= '0;
                        bus.first_idx   <= NO_MATCH;
                        det_rst_q       <= 1'b0;
                        bus.busy        <= 1'b1;
                        state           <= CLEAR;
                    end
                end
                CLEAR: begin
                    det_rst_q <= 1'b1;
                    if (len == 5'd0) begin
                        state <= DRAIN;
                    end else begin
                        bus.det_x <= shreg[0];
                        shreg     <= shreg >> 1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (idx == len - 5'd1) begin
                        bus.det_x <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        idx       <= idx + 5'd1;
                        bus.det_x <= shreg[0];
                        shreg     <= shreg >> 1;
                    end
                end
                DRAIN: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_moore_seq_controller.sv
// tb/tb_moore_seq_controller.sv - two controllers (CNT_W 8 and 2) driving 1101 detectors, checked against a run model
`timescale 1ns/1ps
module tb_moore_seq_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] pat_data = 16'h0;
    logic [4:0]  pat_len = 5'd0;

    always #5 clk = ~clk;

    moore_seq_controller_if #(.MAX_LEN(16), .CNT_W(8)) bus0 ();
    moore_seq_controller_if #(.MAX_LEN(16), .CNT_W(2)) bus1 ();

    moore_seq_controller #(.MAX_LEN(16), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    moore_seq_controller #(.MAX_LEN(16), .CNT_W(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    assign bus0.start = start;  assign bus0.pat_data = pat_data;  assign bus0.pat_len = pat_len;
    assign bus1.start = start;  assign bus1.pat_data = pat_data;  assign bus1.pat_len = pat_len;

    // Detectors: an overlapping 1101 Moore detector flags exactly when the last four bits were 1,1,0,1.
    logic [3:0] hist0 = 4'd0;
    logic [3:0] hist1 = 4'd0;
    always @(posedge clk) hist0 <= bus0.det_rst_n ? {hist0[2:0], bus0.det_x} : 4'd0;
    always @(posedge clk) hist1 <= bus1.det_rst_n ? {hist1[2:0], bus1.det_x} : 4'd0;
    assign bus0.det_z = (hist0 == 4'b1101);
    assign bus1.det_z = (hist1 == 4'b1101);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int count_hits(input logic [15:0] p, input int n);
        int c = 0;
        for (int k = 3; k < n; k++)
            if (p[k-3] && p[k-2] && !p[k-1] && p[k]) c++;
        return c;
    endfunction

    function automatic int first_hit(input logic [15:0] p, input int n);
        for (int k = 3; k < n; k++)
            if (p[k-3] && p[k-2] && !p[k-1] && p[k]) return k;
        return 31;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Run model: m_off is the cycle offset from the start cycle (1 = CLEAR, L+3 = done).
    bit          m_act = 1'b0;
    int          m_off = 0;
    int          m_len = 0;
    logic [15:0] m_pat = 16'h0;
    int          fin_cnt = 0, fin_first = 31;
    int          m_cnt = 0, m_first = 31;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act = 1'b0; m_cnt = 0; m_first = 31;
        end else if (m_act) begin
            if (m_off == m_len + 3) m_act = 1'b0;
            else begin
                m_off++;
                if (m_off == m_len + 3) begin m_cnt = fin_cnt; m_first = fin_first; end
            end
        end else if (start) begin
            m_act = 1'b1; m_off = 1; m_pat = pat_data;
            m_len = (pat_len > 5'd16) ? 16 : int'(pat_len);
            fin_cnt = count_hits(m_pat, m_len); fin_first = first_hit(m_pat, m_len);
            m_cnt = 0; m_first = 31;
        end
    end

    always @(negedge clk) begin
        bit busy_e, done_e, rstn_e, x_e, res_ok;
        busy_e = m_act && (m_off <= m_len + 2);
        done_e = m_act && (m_off == m_len + 3);
        rstn_e = !rst && !(m_act && m_off == 1);
        x_e    = (m_act && m_off >= 2 && m_off <= m_len + 1) ? m_pat[m_off-2] : 1'b0;
        res_ok = !(m_act && m_off >= 2 && m_off <= m_len + 2);
        chk("busy0", int'(bus0.busy), int'(busy_e));
        chk("done0", int'(bus0.done), int'(done_e));
        chk("det_rst_n0", int'(bus0.det_rst_n), int'(rstn_e));
        chk("det_x0", int'(bus0.det_x), int'(x_e));
        chk("busy1", int'(bus1.busy), int'(busy_e));
        chk("done1", int'(bus1.done), int'(done_e));
        chk("det_x1", int'(bus1.det_x), int'(x_e));
        if (res_ok) begin
            chk("match_count0", int'(bus0.match_count), sat(m_cnt, 255));
            chk("first_idx0", int'(bus0.first_idx), m_first);
            chk("match_count1", int'(bus1.match_count), sat(m_cnt, 3));
            chk("first_idx1", int'(bus1.first_idx), m_first);
        end
    end

    task automatic run(input logic [15:0] d, input logic [4:0] n, input int exp_done,
                       input int exp_c0, input int exp_f, input int exp_c1, input string tag);
        int c;
        bit seen;
        @(posedge clk); #1;
        pat_data = d; pat_len = n; start = 1'b1;
        c = 0; seen = 1'b0;
        while (!seen && c < 60) begin
            @(posedge clk); c++; #1;
            if (c == 1) begin start = 1'b0; pat_data = 16'($urandom); pat_len = 5'($urandom); end
            @(negedge clk);
            if (bus0.done) seen = 1'b1;
        end
        chk({tag, "_done_cycle"}, seen ? c : -1, exp_done);
        chk({tag, "_count8"}, int'(bus0.match_count), exp_c0);
        chk({tag, "_first"}, int'(bus0.first_idx), exp_f);
        chk({tag, "_count2"}, int'(bus1.match_count), exp_c1);
    endtask

    initial begin
        int c, n_done, d1, d2;
        @(negedge clk);
        chk("reset_busy", int'(bus0.busy), 0);
        chk("reset_det_rst_n", int'(bus0.det_rst_n), 0);
        chk("reset_first", int'(bus0.first_idx), 31);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run(16'h000B, 5'd4,  7,  1, 3,  1, "seq1101");
        run(16'h005B, 5'd7,  10, 2, 3,  2, "overlap");
        run(16'h0007, 5'd3,  6,  0, 31, 0, "nomatch");
        run(16'hB6DB, 5'd0,  3,  0, 31, 0, "len0");
        run(16'hB6DB, 5'd16, 19, 5, 3,  3, "full16");

        // start held high: second run only begins from IDLE after the first done.
        @(posedge clk); #1;
        pat_data = 16'hB6DB; pat_len = 5'd20; start = 1'b1;
        c = 0; n_done = 0; d1 = -1; d2 = -1;
        while (n_done < 2 && c < 100) begin
            @(posedge clk); c++; #1;
            @(negedge clk);
            if (bus0.done) begin
                if (n_done == 0) d1 = c; else d2 = c;
                n_done++;
            end
        end
        start = 1'b0;
        chk("b2b_first_done", d1, 19);
        chk("b2b_second_done", d2, 39);
        chk("b2b_count8", int'(bus0.match_count), 5);
        chk("b2b_count2", int'(bus1.match_count), 3);

        // Reset in cycle 4 of a run.
        @(posedge clk); #1;
        pat_data = 16'h005B; pat_len = 5'd7; start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(bus0.busy), 0);
        chk("midrst_det_rst_n", int'(bus0.det_rst_n), 0);
        chk("midrst_count", int'(bus0.match_count), 0);
        chk("midrst_first", int'(bus0.first_idx), 31);
        chk("midrst_done", int'(bus0.done), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run(16'h000B, 5'd4, 7, 1, 3, 1, "after_rst");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
